// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for bcd_updown_counter: count/load controls in, BCD count and flags out.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 3
);
    // en and load are level-sampled on every rising clk edge; there is no back-pressure.
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   cnt;
    logic                  tc;
    logic                  co;
    logic                  load_err;

    modport master (
        output en, up, load, load_val,
        input  cnt, tc, co, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output cnt, tc, co, load_err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit 8421-BCD up/down counter with validated parallel load and carry/borrow pulse.
// Define BCD_CNT_SAT_EN for saturating mode (no wrap, co tied low).
module bcd_updown_counter #(
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_updown_counter_if.slave     bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] cnt_q, cnt_d;
    logic         co_q, co_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] cnt_step;
    logic         chain_en;
    logic         all9;
    logic         all0;
    logic         load_ok;
    logic         wrap;

    // Digit k steps only when every lower digit is at its turnover value.
    always_comb begin
        cnt_step = cnt_q;
        chain_en = bus.en;
        all9     = 1'b1;
        all0     = 1'b1;
        load_ok  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (chain_en) begin
                if (bus.up) begin
                    cnt_step[4*k +: 4] = (cnt_q[4*k +: 4] == 4'd9) ? 4'd0 : cnt_q[4*k +: 4] + 4'd1;
                end else begin
                    cnt_step[4*k +: 4] = (cnt_q[4*k +: 4] == 4'd0) ? 4'd9 : cnt_q[4*k +: 4] - 4'd1;
                end
            end
            chain_en = chain_en & (bus.up ? (cnt_q[4*k +: 4] == 4'd9) : (cnt_q[4*k +: 4] == 4'd0));
            all9     = all9 & (cnt_q[4*k +: 4] == 4'd9);
            all0     = all0 & (cnt_q[4*k +: 4] == 4'd0);
            load_ok  = load_ok & (bus.load_val[4*k +: 4] <= 4'd9);
        end
        wrap = bus.en & (bus.up ? all9 : all0);
    end

    always_comb begin
        cnt_d      = cnt_q;
        co_d       = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                cnt_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
`ifdef BCD_CNT_SAT_EN
            if (!wrap) begin
                cnt_d = cnt_step;
            end
`else
            cnt_d = cnt_step;
            co_d  = wrap;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            co_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            co_q       <= co_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.tc       = bus.up ? all9 : all0;
    assign bus.co       = co_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter (DIGITS=3): directed scenarios plus randomized traffic against an integer model.
module tb_bcd_updown_counter;
    localparam int D    = 3;
    localparam int W    = 4 * D;
    localparam int MODV = 1000;

    logic clk;
    logic rst;

    bcd_updown_counter_if #(.DIGITS(D)) bus ();

    bcd_updown_counter #(.DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the count as a plain integer 0..999.
    int   m_val = 0;
    logic m_co  = 1'b0;
    logic m_err = 1'b0;

    logic [W+1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] x);
        for (int k = 0; k < D; k++) begin
            if (int'(x[4*k +: 4]) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] x);
        int v;
        int p;
        v = 0;
        p = 1;
        for (int k = 0; k < D; k++) begin
            v = v + int'(x[4*k +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    // Drives one clock of stimulus, advances the model, returns 1 time unit after the edge.
    task automatic step(input logic r, input logic l, input logic [W-1:0] lv,
                        input logic e, input logic u);
        int nxt;
        rst          = r;
        bus.load     = l;
        bus.load_val = lv;
        bus.en       = e;
        bus.up       = u;
        @(posedge clk);
        m_co  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_val = 0;
        end else if (l) begin
            if (bcd_ok(lv)) m_val = bcd_to_int(lv);
            else            m_err = 1'b1;
        end else if (e) begin
            nxt = u ? m_val + 1 : m_val - 1;
            if (nxt == MODV || nxt == -1) begin
`ifdef BCD_CNT_SAT_EN
                nxt = m_val;
`else
                nxt  = (nxt + MODV) % MODV;
                m_co = 1'b1;
`endif
            end
            m_val = nxt;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if ({bus.cnt, bus.co, bus.load_err} !== {12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: cnt=%h co=%b err=%b required cnt=000 co=0 err=0", bus.cnt, bus.co, bus.load_err);
        end
    endtask

    task automatic test_count_up();
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            checks++;
            if ({bus.cnt, bus.co} !== {to_bcd(i), 1'b0}) begin
                errors++;
                $display("FAIL count_up[%0d]: cnt=%h co=%b required cnt=%h co=0", i, bus.cnt, bus.co, to_bcd(i));
            end
        end
        checks++;
        if (bus.cnt !== 12'h012) begin
            errors++;
            $display("FAIL count_up_end: cnt=%h required 012", bus.cnt);
        end
    endtask

    task automatic test_rollover();
        step(1'b0, 1'b1, 12'h099, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if ({bus.cnt, bus.co} !== {12'h100, 1'b0}) begin
            errors++;
            $display("FAIL decade_roll: cnt=%h co=%b required cnt=100 co=0", bus.cnt, bus.co);
        end
        step(1'b0, 1'b1, 12'h999, 1'b0, 1'b1);
        checks++;
        if ({bus.tc, bus.co} !== 2'b10) begin
            errors++;
            $display("FAIL tc_at_999: tc=%b co=%b required tc=1 co=0", bus.tc, bus.co);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
`ifdef BCD_CNT_SAT_EN
        if ({bus.cnt, bus.co} !== {12'h999, 1'b0}) begin
            errors++;
            $display("FAIL sat_up: cnt=%h co=%b required cnt=999 co=0", bus.cnt, bus.co);
        end
`else
        if ({bus.cnt, bus.co} !== {12'h000, 1'b1}) begin
            errors++;
            $display("FAIL wrap_up: cnt=%h co=%b required cnt=000 co=1", bus.cnt, bus.co);
        end
`endif
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (bus.co !== 1'b0) begin
            errors++;
            $display("FAIL co_one_cycle: co=%b required 0", bus.co);
        end
    endtask

    task automatic test_down_borrow();
        step(1'b0, 1'b1, 12'h100, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if ({bus.cnt, bus.co} !== {12'h099, 1'b0}) begin
            errors++;
            $display("FAIL borrow_digit: cnt=%h co=%b required cnt=099 co=0", bus.cnt, bus.co);
        end
        step(1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
        checks++;
        if (bus.tc !== 1'b1) begin
            errors++;
            $display("FAIL tc_at_000: tc=%b required 1", bus.tc);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
`ifdef BCD_CNT_SAT_EN
        if ({bus.cnt, bus.co} !== {12'h000, 1'b0}) begin
            errors++;
            $display("FAIL sat_down: cnt=%h co=%b required cnt=000 co=0", bus.cnt, bus.co);
        end
`else
        if ({bus.cnt, bus.co} !== {12'h999, 1'b1}) begin
            errors++;
            $display("FAIL wrap_down: cnt=%h co=%b required cnt=999 co=1", bus.cnt, bus.co);
        end
`endif
    endtask

    task automatic test_invalid_load();
        step(1'b0, 1'b1, 12'h456, 1'b0, 1'b1);
        step(1'b0, 1'b1, 12'h3A7, 1'b1, 1'b1);
        checks++;
        if ({bus.cnt, bus.load_err, bus.co} !== {12'h456, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bad_load: cnt=%h err=%b co=%b required cnt=456 err=1 co=0", bus.cnt, bus.load_err, bus.co);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if ({bus.cnt, bus.load_err} !== {12'h456, 1'b0}) begin
            errors++;
            $display("FAIL bad_load_after: cnt=%h err=%b required cnt=456 err=0", bus.cnt, bus.load_err);
        end
    endtask

    task automatic test_priority();
        step(1'b1, 1'b1, 12'h321, 1'b1, 1'b1);
        checks++;
        if ({bus.cnt, bus.co, bus.load_err} !== {12'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_over_load: cnt=%h co=%b err=%b required cnt=000 co=0 err=0", bus.cnt, bus.co, bus.load_err);
        end
        step(1'b0, 1'b1, 12'h321, 1'b1, 1'b1);
        checks++;
        if (bus.cnt !== 12'h321) begin
            errors++;
            $display("FAIL load_over_en: cnt=%h required 321", bus.cnt);
        end
    endtask

    task automatic test_direction_toggle();
        logic [W-1:0] want;
        step(1'b0, 1'b1, 12'h500, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, (i % 2 == 0));
            want = (i % 2 == 0) ? 12'h501 : 12'h500;
            checks++;
            if ({bus.cnt, bus.co} !== {want, 1'b0}) begin
                errors++;
                $display("FAIL toggle[%0d]: cnt=%h co=%b required cnt=%h co=0", i, bus.cnt, bus.co, want);
            end
        end
    endtask

    task automatic test_random();
        logic         r, l, e, u, exp_tc;
        logic [W-1:0] lv;
        logic [W+1:0] want;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       lv = W'($urandom_range(0, 4095));
                1:       lv = 12'h999;
                2:       lv = 12'h000;
                default: lv = to_bcd(int'($urandom_range(0, 999)));
            endcase
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            bus.up = u;
            #1;
            exp_tc = u ? (m_val == MODV - 1) : (m_val == 0);
            checks++;
            if (bus.tc !== exp_tc) begin
                errors++;
                $display("FAIL rand_tc[%0d]: tc=%b required %b", i, bus.tc, exp_tc);
            end
            step(r, l, lv, e, u);
            exp_q.push_back({to_bcd(m_val), m_co, m_err});
            want = exp_q.pop_front();
            checks++;
            if ({bus.cnt, bus.co, bus.load_err} !== want) begin
                errors++;
                $display("FAIL rand_out[%0d]: cnt=%h co=%b err=%b required cnt=%h co=%b err=%b",
                         i, bus.cnt, bus.co, bus.load_err, want[W+1:2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_rollover();
        test_down_borrow();
        test_invalid_load();
        test_priority();
        test_direction_toggle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
